// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - pattern word handshake and serial control stream bundle
interface seq_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int GAP_W = 4
);
    localparam int LW = $clog2(WIDTH) + 1;

    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_data;
    logic [LW-1:0]    in_len;
    logic [3:0]       in_rep;
    logic [GAP_W-1:0] in_gap;
    logic             C;
    logic             C_vld;
    logic             done;
    logic             err;
    logic             busy;

    modport master (
        output in_vld, in_data, in_len, in_rep, in_gap,
        input  in_rdy, C, C_vld, done, err, busy
    );

    modport slave (
        input  in_vld, in_data, in_len, in_rep, in_gap,
        output in_rdy, C, C_vld, done, err, busy
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serializes buffered pattern words MSB-first with repeat and gap control
module seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_pattern_gen_if.slave bus
);
    localparam int LW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [3:0]       rep_left, rep_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [WIDTH-1:0] act_data, act_data_n;
    logic [IW-1:0]    act_last, act_last_n;
    logic [GAP_W-1:0] act_gap, act_gap_n;

    logic             pend_full, pend_full_n;
    logic [WIDTH-1:0] pend_data;
    logic [IW-1:0]    pend_last;
    logic [3:0]       pend_rep;
    logic [GAP_W-1:0] pend_gap;

    logic             c_q, c_vld_q, done_q, err_q, busy_q;
    logic             c_n, c_vld_n, done_n, busy_n;
    logic             rdy, accept, store, load;
    logic [LW-1:0]    len_clamped;
    logic [IW-1:0]    in_last;

    assign rdy         = !pend_full && !rst;
    assign accept      = bus.in_vld && rdy;
    assign store       = accept && (bus.in_len != '0);
    assign len_clamped = (bus.in_len > LW'(WIDTH)) ? LW'(WIDTH) : bus.in_len;
    assign in_last     = IW'(len_clamped - LW'(1));

    // rep_left==0 while in GAP marks the trailing gap before a queued word
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        rep_n      = rep_left;
        gap_cnt_n  = gap_cnt;
        act_data_n = act_data;
        act_last_n = act_last;
        act_gap_n  = act_gap;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_full) load = 1'b1;
            end
            S_SHIFT: begin
                if (idx != '0) begin
                    idx_n = idx - IW'(1);
                end else if (rep_left > 4'd1) begin
                    rep_n = rep_left - 4'd1;
                    if (act_gap == '0) begin
                        idx_n = act_last;
                    end else begin
                        state_n   = S_GAP;
                        gap_cnt_n = act_gap;
                    end
                end else if (pend_full) begin
                    if (act_gap == '0) begin
                        load = 1'b1;
                    end else begin
                        state_n   = S_GAP;
                        gap_cnt_n = act_gap;
                        rep_n     = 4'd0;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt > GAP_W'(1)) begin
                    gap_cnt_n = gap_cnt - GAP_W'(1);
                end else if (rep_left != 4'd0) begin
                    state_n = S_SHIFT;
                    idx_n   = act_last;
                end else if (pend_full) begin
                    load = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (load) begin
            state_n    = S_SHIFT;
            act_data_n = pend_data;
            act_last_n = pend_last;
            act_gap_n  = pend_gap;
            idx_n      = pend_last;
            rep_n      = (pend_rep == 4'd0) ? 4'd1 : pend_rep;
            gap_cnt_n  = '0;
        end

        pend_full_n = (pend_full && !load) || store;
        c_vld_n     = (state_n == S_SHIFT);
        c_n         = c_vld_n && act_data_n[idx_n];
        done_n      = c_vld_n && (idx_n == '0) && (rep_n == 4'd1);
        busy_n      = (state_n != S_IDLE) || pend_full_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            rep_left  <= '0;
            gap_cnt   <= '0;
            act_data  <= '0;
            act_last  <= '0;
            act_gap   <= '0;
            pend_full <= 1'b0;
            pend_data <= '0;
            pend_last <= '0;
            pend_rep  <= '0;
            pend_gap  <= '0;
            c_q       <= 1'b0;
            c_vld_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            rep_left  <= rep_n;
            gap_cnt   <= gap_cnt_n;
            act_data  <= act_data_n;
            act_last  <= act_last_n;
            act_gap   <= act_gap_n;
            pend_full <= pend_full_n;
            if (store) begin
                pend_data <= bus.in_data;
                pend_last <= in_last;
                pend_rep  <= bus.in_rep;
                pend_gap  <= bus.in_gap;
            end
            c_q     <= c_n;
            c_vld_q <= c_vld_n;
            done_q  <= done_n;
            err_q   <= accept && (bus.in_len == '0);
            busy_q  <= busy_n;
        end
    end

    assign bus.in_rdy = rdy;
    assign bus.C      = c_q;
    assign bus.C_vld  = c_vld_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
endmodule
